time_set_ctrl: RTL and testbench

Time-setting controller for the digital clock. It debounces the six set buttons (HU, HD, MU, MD, SU, SD) and captures the running time from the timer's Q_H/Q_M/Q_S. It edits a BCD shadow copy of that time and drives the timer's synchronous load port (PE, D_H, D_M, D_S) until the edited value has been committed on a 1 Hz timer edge. It sits between the frequency divider (clocked from the 10 kHz output) and the timer, taking the place of the top level's fixed PE/D drive.

---
 rtl/time_set_ctrl.sv | 146 ++++++++++++++
 tb/tb_time_set_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// Time-setting controller: debounces six set buttons, edits a BCD shadow of the
// running time and holds the timer's load port until a 1 Hz edge commits it.
module time_set_ctrl #(
  parameter int unsigned DEB_CYCLES     = 200,
  parameter int unsigned TIMEOUT_CYCLES = 30000
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       TICK,
  input  logic       HU,
  input  logic       HD,
  input  logic       MU,
  input  logic       MD,
  input  logic       SU,
  input  logic       SD,
  input  logic [7:0] Q_H,
  input  logic [7:0] Q_M,
  input  logic [7:0] Q_S,
  output logic       PE,
  output logic [7:0] D_H,
  output logic [7:0] D_M,
  output logic [7:0] D_S,
  output logic       SET
);

  localparam int unsigned DCW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_EDIT, S_COMMIT} state_t;

  state_t           r_state, w_state_nxt;
  logic [5:0]       w_raw;
  logic [5:0]       r_sync1, r_sync2, r_deb, r_press;
  logic [DCW-1:0]   r_deb_cnt [6];
  logic [TCW-1:0]   r_tcnt, w_tcnt_nxt;
  logic [7:0]       r_d_h, r_d_m, r_d_s;
  logic [7:0]       w_d_h_nxt, w_d_m_nxt, w_d_s_nxt;
  logic [7:0]       w_base_h, w_base_m, w_base_s;
  logic [7:0]       w_step_h, w_step_m, w_step_s;
  logic             w_any_press;
  logic             r_pe;

  // Bit order: [5]HU [4]HD [3]MU [2]MD [1]SU [0]SD
  assign w_raw = {HU, HD, MU, MD, SU, SD};

  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_press <= '0;
      for (int unsigned i = 0; i < 6; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int unsigned i = 0; i < 6; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync2[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DCW'(DEB_CYCLES - 1)) begin
          r_deb[i]     <= r_sync2[i];
          r_deb_cnt[i] <= '0;
          r_press[i]   <= r_sync2[i];
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Opposing presses cancel; an out-of-range field snaps to 00 on any step.
  function automatic logic [7:0] f_step(input logic [7:0] v, input logic [7:0] vmax,
                                        input logic up, input logic dn);
    logic [7:0] r;
    r = v;
    if (up ^ dn) begin
      if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v > vmax)
        r = 8'h00;
      else if (up)
        r = (v == vmax) ? 8'h00 :
            (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
      else
        r = (v == 8'h00) ? vmax :
            (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : v - 8'd1;
    end
    return r;
  endfunction

  assign w_any_press = |r_press;
  assign w_base_h    = (r_state == S_IDLE) ? Q_H : r_d_h;
  assign w_base_m    = (r_state == S_IDLE) ? Q_M : r_d_m;
  assign w_base_s    = (r_state == S_IDLE) ? Q_S : r_d_s;
  assign w_step_h    = f_step(w_base_h, 8'h23, r_press[5], r_press[4]);
  assign w_step_m    = f_step(w_base_m, 8'h59, r_press[3], r_press[2]);
  assign w_step_s    = f_step(w_base_s, 8'h59, r_press[1], r_press[0]);

  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    w_d_h_nxt   = r_d_h;
    w_d_m_nxt   = r_d_m;
    w_d_s_nxt   = r_d_s;
    if (w_any_press) begin
      w_state_nxt = S_EDIT;
      w_tcnt_nxt  = '0;
      w_d_h_nxt   = w_step_h;
      w_d_m_nxt   = w_step_m;
      w_d_s_nxt   = w_step_s;
    end else begin
      case (r_state)
        S_IDLE:   ;
        S_EDIT: begin
          if (r_tcnt == TCW'(TIMEOUT_CYCLES - 1)) w_state_nxt = S_COMMIT;
          else                                    w_tcnt_nxt  = r_tcnt + 1'b1;
        end
        S_COMMIT: if (TICK) w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      r_state <= S_IDLE;
      r_tcnt  <= '0;
      r_d_h   <= '0;
      r_d_m   <= '0;
      r_d_s   <= '0;
      r_pe    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_d_h   <= w_d_h_nxt;
      r_d_m   <= w_d_m_nxt;
      r_d_s   <= w_d_s_nxt;
      r_pe    <= (w_state_nxt != S_IDLE);
    end
  end

  assign PE  = r_pe;
  assign SET = r_pe;
  assign D_H = r_d_h;
  assign D_M = r_d_m;
  assign D_S = r_d_s;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl with shortened debounce/timeout constants.
module tb_time_set_ctrl;

  localparam int DEB = 8;
  localparam int TO  = 100;

  logic       CP = 1'b0;
  logic       CR = 1'b1;
  logic       TICK = 1'b0;
  logic       HU = 1'b0, HD = 1'b0, MU = 1'b0, MD = 1'b0, SU = 1'b0, SD = 1'b0;
  logic [7:0] Q_H = 8'h00, Q_M = 8'h00, Q_S = 8'h00;
  logic       PE, SET;
  logic [7:0] D_H, D_M, D_S;

  time_set_ctrl #(.DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TO)) dut (
    .CP(CP), .CR(CR), .TICK(TICK),
    .HU(HU), .HD(HD), .MU(MU), .MD(MD), .SU(SU), .SD(SD),
    .Q_H(Q_H), .Q_M(Q_M), .Q_S(Q_S),
    .PE(PE), .D_H(D_H), .D_M(D_M), .D_S(D_S), .SET(SET)
  );

  always #5 CP = ~CP;

  int cyc = 0;
  always @(posedge CP) cyc <= cyc + 1;

  typedef struct {
    logic       pe;
    logic       set;
    logic [7:0] dh;
    logic [7:0] dm;
    logic [7:0] ds;
    int         cyc;
  } exp_t;

  exp_t sb[$];     // expected output changes, in order
  exp_t snap[$];   // expected output levels at the next sample point

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  bit done = 1'b0;
  logic [25:0] cur, prev, ev;
  exp_t e;

  always @(negedge CP) begin
    cur = {PE, SET, D_H, D_M, D_S};
    if (mon_en && cur !== prev) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_change got=%h prev=%h cyc=%0d", cur, prev, cyc);
      end else begin
        e  = sb.pop_front();
        ev = {e.pe, e.set, e.dh, e.dm, e.ds};
        checks++;
        if (cur !== ev) begin
          failures++;
          $display("FAIL out_value got=%h exp=%h cyc=%0d", cur, ev, cyc);
        end
        if (e.cyc >= 0) begin
          checks++;
          if (cyc != e.cyc) begin
            failures++;
            $display("FAIL out_timing got_cyc=%0d exp_cyc=%0d", cyc, e.cyc);
          end
        end
      end
    end
    if (snap.size() != 0) begin
      e  = snap.pop_front();
      ev = {e.pe, e.set, e.dh, e.dm, e.ds};
      checks++;
      if (cur !== ev) begin
        failures++;
        $display("FAIL snapshot got=%h exp=%h cyc=%0d", cur, ev, cyc);
      end
    end
    prev = cur;
    if (done) begin
      checks++;
      if (sb.size() != 0) begin
        failures++;
        $display("FAIL pending_events got=%0d exp=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge CP); #1;
    end
  endtask

  task automatic press(input logic [5:0] m, input int hold, input bit chg,
                       input logic [7:0] h, input logic [7:0] mm, input logic [7:0] s,
                       output int u);
    int c0;
    @(posedge CP); #1;
    c0 = cyc;
    u  = c0 + DEB + 3;
    if (chg) sb.push_back('{1'b1, 1'b1, h, mm, s, u});
    {HU, HD, MU, MD, SU, SD} = m;
    wait_cyc(c0 + hold);
    {HU, HD, MU, MD, SU, SD} = 6'b0;
    wait_cyc(c0 + hold + DEB + 4);
  endtask

  // First TICK lands one cycle before COMMIT and must be ignored.
  task automatic commit(input int u, input logic [7:0] h, input logic [7:0] mm,
                        input logic [7:0] s);
    wait_cyc(u + TO - 1);
    TICK = 1'b1;
    wait_cyc(u + TO);
    TICK = 1'b0;
    wait_cyc(u + TO + 2);
    sb.push_back('{1'b0, 1'b0, h, mm, s, u + TO + 3});
    TICK = 1'b1;
    wait_cyc(u + TO + 3);
    TICK = 1'b0;
    wait_cyc(u + TO + 6);
  endtask

  initial begin
    int u, u2, c0;
    #1 CR = 1'b0;
    repeat (3) @(posedge CP);
    #1 CR = 1'b1;
    mon_en = 1'b1;
    wait_cyc(cyc + 1000);
    snap.push_back('{1'b0, 1'b0, 8'h00, 8'h00, 8'h00, -1});

    Q_H = 8'h12; Q_M = 8'h34; Q_S = 8'h56;
    press(6'b100000, DEB + 5, 1'b1, 8'h13, 8'h34, 8'h56, u);
    commit(u, 8'h13, 8'h34, 8'h56);

    Q_H = 8'h23; Q_M = 8'h00; Q_S = 8'h09;
    press(6'b100000, DEB + 5, 1'b1, 8'h00, 8'h00, 8'h09, u);
    press(6'b000100, DEB + 5, 1'b1, 8'h00, 8'h59, 8'h09, u);
    press(6'b000010, DEB + 5, 1'b1, 8'h00, 8'h59, 8'h10, u);
    press(6'b000001, DEB + 5, 1'b1, 8'h00, 8'h59, 8'h09, u);
    press(6'b010000, DEB + 5, 1'b1, 8'h23, 8'h59, 8'h09, u);
    commit(u, 8'h23, 8'h59, 8'h09);

    Q_H = 8'h3A; Q_M = 8'h00; Q_S = 8'h00;
    press(6'b010000, DEB + 5, 1'b1, 8'h00, 8'h00, 8'h00, u);
    commit(u, 8'h00, 8'h00, 8'h00);

    Q_H = 8'h10; Q_M = 8'h20; Q_S = 8'h30;
    press(6'b110010, DEB + 5, 1'b1, 8'h10, 8'h20, 8'h31, u);
    commit(u, 8'h10, 8'h20, 8'h31);

    press(6'b001000, DEB - 1, 1'b0, 8'h00, 8'h00, 8'h00, u);
    snap.push_back('{1'b0, 1'b0, 8'h10, 8'h20, 8'h31, -1});
    press(6'b001000, 10 * DEB, 1'b1, 8'h10, 8'h21, 8'h30, u);
    commit(u, 8'h10, 8'h21, 8'h30);

    // SD press pulse and TICK are both sampled at edge u+TO+5, in COMMIT.
    Q_H = 8'h05; Q_M = 8'h05; Q_S = 8'h05;
    press(6'b000010, DEB + 5, 1'b1, 8'h05, 8'h05, 8'h06, u);
    wait_cyc(u + TO - 6);
    c0 = cyc;
    u2 = c0 + DEB + 3;
    sb.push_back('{1'b1, 1'b1, 8'h05, 8'h05, 8'h05, u2});
    SD = 1'b1;
    wait_cyc(u2 - 1);
    TICK = 1'b1;
    wait_cyc(u2);
    TICK = 1'b0;
    wait_cyc(c0 + DEB + 5);
    SD = 1'b0;
    wait_cyc(u2 + 3);
    TICK = 1'b1;
    wait_cyc(u2 + 4);
    TICK = 1'b0;
    wait_cyc(u2 + 15);
    sb.push_back('{1'b0, 1'b0, 8'h00, 8'h00, 8'h00, -1});
    CR = 1'b0;
    wait_cyc(u2 + 17);
    snap.push_back('{1'b0, 1'b0, 8'h00, 8'h00, 8'h00, -1});
    wait_cyc(u2 + 18);
    CR = 1'b1;
    wait_cyc(u2 + 40);
    done = 1'b1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d exp=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
